// File: rtl/branch_resolve_unit.sv
// Registered EX-stage branch resolver: evaluates the condition, computes the redirect PC and
// flags mispredicts. Optional handshake statistics are built when BRU_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  input  logic [7:0]         operation,
  input  logic [WIDTH-1:0]   pc,
  input  logic [WIDTH-1:0]   imm,
  input  logic               pred_taken,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               taken,
  output logic [WIDTH-1:0]   redirect_pc,
  output logic               mispredict,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] br_count,
  output logic [COUNT_W-1:0] mp_count
);

  typedef struct packed {
    logic             taken;
    logic             mispredict;
    logic             illegal_op;
    logic [WIDTH-1:0] redirect_pc;
  } res_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  res_t res_q, res_d, res_new;
  logic out_valid_q, out_valid_d;
  logic accept, handshake;
  logic eq, lt_s, lt_u, cond, illegal;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    eq      = (srcA == srcB);
    lt_s    = ($signed(srcA) < $signed(srcB));
    lt_u    = (srcA < srcB);
    cond    = 1'b0;
    illegal = 1'b0;
    case (operation)
      8'h00:   cond = eq;
      8'h01:   cond = !eq;
      8'h04:   cond = lt_s;
      8'h05:   cond = !lt_s;
      8'h06:   cond = lt_u;
      8'h07:   cond = !lt_u;
      8'h08:   cond = 1'b1;
      default: illegal = 1'b1;
    endcase
    // illegal ops resolve not-taken, so mispredict falls out as pred_taken
    res_new.taken       = cond;
    res_new.illegal_op  = illegal;
    res_new.mispredict  = cond ^ pred_taken;
    res_new.redirect_pc = cond ? (pc + imm) : (pc + PC_STEP);
  end

  always_comb begin
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      res_d       = res_new;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign taken       = res_q.taken;
  assign mispredict  = res_q.mispredict;
  assign illegal_op  = res_q.illegal_op;
  assign redirect_pc = res_q.redirect_pc;

`ifdef BRU_STATS_EN
  logic [COUNT_W-1:0] br_count_q, br_count_d;
  logic [COUNT_W-1:0] mp_count_q, mp_count_d;

  // saturating counters; flush deliberately leaves them alone
  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (handshake && (br_count_q != '1))
      br_count_d = br_count_q + COUNT_W'(1);
    if (handshake && res_q.mispredict && (mp_count_q != '1))
      mp_count_d = mp_count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;
`else
  assign br_count = '0;
  assign mp_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed cases then random traffic against a reference model.
module tb_branch_resolve_unit;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  srcA = '0, srcB = '0, pc = '0, imm = '0;
  logic [7:0]    operation = '0;
  logic          pred_taken = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          taken, mispredict, illegal_op;
  logic [W-1:0]  redirect_pc;
  logic [CW-1:0] br_count, mp_count;

  int n_assert = 0;
  int n_fail   = 0;

  // reference state
  logic          m_valid = 1'b0, m_taken = 1'b0, m_mp = 1'b0, m_ill = 1'b0;
  logic [W-1:0]  m_rpc = '0;
  int            m_br = 0, m_mpc = 0;

  branch_resolve_unit #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .srcA(srcA), .srcB(srcB), .operation(operation), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .redirect_pc(redirect_pc), .mispredict(mispredict), .illegal_op(illegal_op),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Branch semantics from plain integer arithmetic on 64-bit values.
  function automatic void ref_br(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] im, input logic pr,
                                 output logic t, output logic il, output logic mp,
                                 output logic [31:0] rpc);
    longint sa, sb, ua, ub, nxt;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[31] ? ua - (64'sd1 <<< 32) : ua;
    sb = b[31] ? ub - (64'sd1 <<< 32) : ub;
    il = 1'b0;
    case (op)
      8'h00:   t = (ua == ub);
      8'h01:   t = (ua != ub);
      8'h04:   t = (sa < sb);
      8'h05:   t = (sa >= sb);
      8'h06:   t = (ua < ub);
      8'h07:   t = (ua >= ub);
      8'h08:   t = 1'b1;
      default: begin t = 1'b0; il = 1'b1; end
    endcase
    mp  = (t != pr);
    nxt = t ? (longint'(p) + longint'(im)) : (longint'(p) + 4);
    rpc = nxt[31:0];
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"},   out_valid,   m_valid);
    chk({tag, ".taken"},       taken,       m_taken);
    chk({tag, ".mispredict"},  mispredict,  m_mp);
    chk({tag, ".illegal_op"},  illegal_op,  m_ill);
    chk({tag, ".redirect_pc"}, redirect_pc, m_rpc);
    chk({tag, ".br_count"},    br_count,    64'(m_br));
    chk({tag, ".mp_count"},    mp_count,    64'(m_mpc));
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cyc(input string tag);
    logic exp_rdy, acc, hs, t, il, mp;
    logic [31:0] rpc;
    #1;
    exp_rdy = !m_valid || out_ready;
    chk({tag, ".in_ready"}, in_ready, exp_rdy);
    acc = in_valid && exp_rdy && !flush;
    hs  = m_valid && out_ready;
    ref_br(operation, srcA, srcB, pc, imm, pred_taken, t, il, mp, rpc);
    @(posedge clk);
`ifdef BRU_STATS_EN
    if (hs) begin
      if (m_br < (1 << CW) - 1) m_br++;
      if (m_mp && m_mpc < (1 << CW) - 1) m_mpc++;
    end
`endif
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_taken = t; m_ill = il; m_mp = mp; m_rpc = rpc;
    end else if (hs) m_valid = 1'b0;
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_valid = 0; m_taken = 0; m_mp = 0; m_ill = 0; m_rpc = '0; m_br = 0; m_mpc = 0;
    check_outs("reset");
    chk("reset.in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] im, input logic pr);
    in_valid = 1'b1; operation = op; srcA = a; srcB = b; pc = p; imm = im; pred_taken = pr;
  endtask

  logic [7:0] ops [11];

  initial begin
    ops = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h02, 8'h03, 8'h09, 8'hFF};
    #3;
    check_outs("por");
    chk("por.in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // BEQ taken, predicted not-taken
    out_ready = 1'b1;
    set_in(8'h00, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    cyc("beq");
    chk("beq.valid", out_valid, 1'b1);
    chk("beq.rpc", redirect_pc, 32'h120);
    chk("beq.mp", mispredict, 1'b1);

    // signed vs unsigned less-than
    set_in(8'h04, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0);
    cyc("blt");
    chk("blt.taken", taken, 1'b1);
    chk("blt.rpc", redirect_pc, 32'h240);
    set_in(8'h06, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0);
    cyc("bltu");
    chk("bltu.taken", taken, 1'b0);
    chk("bltu.rpc", redirect_pc, 32'h204);

    // back-pressure: result held, new bundle waits
    set_in(8'h00, 32'd1, 32'd2, 32'h300, 32'h10, 1'b1);
    cyc("bp_load");
    out_ready = 1'b0;
    set_in(8'h01, 32'd1, 32'd2, 32'h400, 32'h8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("bp_hold");
      chk("bp.in_ready", in_ready, 1'b0);
      chk("bp.rpc", redirect_pc, 32'h304);
    end
    out_ready = 1'b1;
    cyc("bp_release");
    chk("bp.valid", out_valid, 1'b1);
    chk("bp.new_rpc", redirect_pc, 32'h408);

    // flush beats a pending result and a same-cycle input
    out_ready = 1'b0; flush = 1'b1;
    set_in(8'h08, 32'd0, 32'd0, 32'h600, 32'h80, 1'b0);
    cyc("flush");
    chk("flush.valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    cyc("post_flush");
    chk("post_flush.valid", out_valid, 1'b0);

    // illegal encoding and PC wrap
    out_ready = 1'b1;
    set_in(8'h02, 32'd3, 32'd3, 32'h500, 32'h10, 1'b1);
    cyc("illegal");
    chk("illegal.ill", illegal_op, 1'b1);
    chk("illegal.taken", taken, 1'b0);
    chk("illegal.mp", mispredict, 1'b1);
    set_in(8'h08, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1'b1);
    cyc("wrap");
    chk("wrap.rpc", redirect_pc, 32'h4);

    // reset while holding discards the result
    out_ready = 1'b0;
    cyc("hold_pre_reset");
    chk("hold.valid", out_valid, 1'b1);
    do_reset();
    chk("mid_reset.valid", out_valid, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom();
      set_in(ops[$urandom_range(0, 10)], a,
             ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom() : a ^ 32'h8000_0000),
             $urandom() & 32'hFFFF_FFFC, $urandom(), 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc("rand");
    end
    flush = 1'b0;

    // stream mispredicting jumps to exercise counter saturation
    out_ready = 1'b1;
    set_in(8'h08, 32'd0, 32'd0, 32'h700, 32'h4, 1'b0);
    for (int i = 0; i < 21; i++) cyc("stats");
`ifdef BRU_STATS_EN
    chk("stats.br_sat", br_count, 4'hF);
    chk("stats.mp_sat", mp_count, 4'hF);
`else
    chk("stats.br_tied", br_count, 4'h0);
    chk("stats.mp_tied", mp_count, 4'h0);
`endif
    in_valid = 1'b0;
    do_reset();
    chk("stats.br_rst", br_count, 4'h0);
    chk("stats.mp_rst", mp_count, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
